// File: rtl/reg_wb_arbiter_if.sv
// reg_wb_arbiter_if: ALU/MDU result inputs, register-file write port and hazard mask
interface reg_wb_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [4:0]            alu_addr;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  mdu_valid;
    logic                  mdu_ready;
    logic [4:0]            mdu_addr;
    logic [DATA_WIDTH-1:0] mdu_data;
    logic                  wr_en;
    logic [4:0]            wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [31:0]           pending_mask;

    modport master (
        output alu_valid, alu_addr, alu_data, mdu_valid, mdu_addr, mdu_data,
        input  alu_ready, mdu_ready, wr_en, wr_addr, wr_data, pending_mask
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data, mdu_valid, mdu_addr, mdu_data,
        output alu_ready, mdu_ready, wr_en, wr_addr, wr_data, pending_mask
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: merges ALU results and FIFO-buffered MDU results onto one register-file write port
module reg_wb_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input logic              clk,
    input logic              rst,
    reg_wb_arbiter_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]            addr_mem_q [DEPTH];
    logic [4:0]            addr_mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_d [DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d, count;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  wr_en_q, wr_en_d;
    logic [4:0]            wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  empty, full, forced, push, pop, src_valid;
    logic [4:0]            src_addr;
    logic [DATA_WIDTH-1:0] src_data;
    logic [AW-1:0]         off;
    logic [31:0]           mask;

    // FIFO status and write-source selection; a pop always makes the head the source
    always_comb begin
        empty     = wptr_q == rptr_q;
        full      = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        forced    = (starve_q == SW'(STARVE_LIMIT)) && !empty;
        push      = bus.mdu_valid && !full;
        pop       = forced || (!bus.alu_valid && !empty);
        src_valid = pop || bus.alu_valid;
        src_addr  = pop ? addr_mem_q[rptr_q[AW-1:0]] : bus.alu_addr;
        src_data  = pop ? data_mem_q[rptr_q[AW-1:0]] : bus.alu_data;
        count     = wptr_q - rptr_q;
    end

    // pending mask: one-hot of every occupied slot, register 0 never reported
    always_comb begin
        mask = '0;
        off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rptr_q[AW-1:0];
            if ({1'b0, off} < count) mask[addr_mem_q[i]] = 1'b1;
        end
        mask[0] = 1'b0;
    end

    // next-state: pointers, storage, starvation counter and output register
    always_comb begin
        wptr_d     = wptr_q + PW'(push);
        rptr_d     = rptr_q + PW'(pop);
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        if (push) begin
            addr_mem_d[wptr_q[AW-1:0]] = bus.mdu_addr;
            data_mem_d[wptr_q[AW-1:0]] = bus.mdu_data;
        end
        starve_d  = (empty || pop) ? '0 :
                    (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
        wr_en_d   = src_valid && (src_addr != 5'd0);
        wr_addr_d = src_valid ? src_addr : wr_addr_q;
        wr_data_d = src_valid ? src_data : wr_data_q;
    end

    // control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            starve_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            starve_q  <= starve_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // FIFO storage needs no reset; occupancy comes from the pointers alone
    always_ff @(posedge clk) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
    end

    assign bus.mdu_ready    = !full;
    assign bus.alu_ready    = !forced;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.pending_mask = mask;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed scenario tests for the writeback arbiter
module tb_reg_wb_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter_if #(.DATA_WIDTH(32)) bus ();

    reg_wb_arbiter #(.DATA_WIDTH(32), .DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.alu_addr  = '0;
        bus.alu_data  = '0;
        bus.mdu_valid = 1'b0;
        bus.mdu_addr  = '0;
        bus.mdu_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.alu_valid = 1'($urandom);
            bus.alu_addr  = 5'($urandom);
            bus.alu_data  = $urandom;
            bus.mdu_valid = 1'($urandom);
            bus.mdu_addr  = 5'($urandom);
            bus.mdu_data  = $urandom;
            tick();
        end
        rst = 1'b0;
        idle();
        #1;
        if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%0h want=0", bus.wr_en); end total++;
        if (bus.wr_addr !== 5'd0) begin bad++; $display("FAIL reset_wr_addr got=%0h want=0", bus.wr_addr); end total++;
        if (bus.wr_data !== 32'd0) begin bad++; $display("FAIL reset_wr_data got=%0h want=0", bus.wr_data); end total++;
        if (bus.pending_mask !== 32'd0) begin bad++; $display("FAIL reset_pending got=%0h want=0", bus.pending_mask); end total++;
        if (bus.mdu_ready !== 1'b1) begin bad++; $display("FAIL reset_mdu_ready got=%0h want=1", bus.mdu_ready); end total++;
        if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL reset_alu_ready got=%0h want=1", bus.alu_ready); end total++;
    endtask

    task automatic test_alu();
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 5'd5;
        bus.alu_data  = 32'hDEADBEEF;
        #1;
        if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL alu_ready got=%0h want=1", bus.alu_ready); end total++;
        tick();
        bus.alu_valid = 1'b0;
        if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL alu_wr_en got=%0h want=1", bus.wr_en); end total++;
        if (bus.wr_addr !== 5'd5) begin bad++; $display("FAIL alu_wr_addr got=%0h want=5", bus.wr_addr); end total++;
        if (bus.wr_data !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_wr_data got=%0h want=deadbeef", bus.wr_data); end total++;
        tick();
        if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL alu_wr_en_after got=%0h want=0", bus.wr_en); end total++;
        if (bus.wr_addr !== 5'd5) begin bad++; $display("FAIL alu_addr_hold got=%0h want=5", bus.wr_addr); end total++;
    endtask

    task automatic test_zero();
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 5'd0;
        bus.alu_data  = 32'h55;
        tick();
        bus.alu_valid = 1'b0;
        if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL zero_alu_wr_en got=%0h want=0", bus.wr_en); end total++;
        bus.mdu_valid = 1'b1;
        bus.mdu_addr  = 5'd0;
        bus.mdu_data  = 32'h1234;
        tick();
        bus.mdu_valid = 1'b0;
        #1;
        if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL zero_push_wr_en got=%0h want=0", bus.wr_en); end total++;
        if (bus.pending_mask !== 32'd0) begin bad++; $display("FAIL zero_pending got=%0h want=0", bus.pending_mask); end total++;
        tick();
        if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL zero_pop_wr_en got=%0h want=0", bus.wr_en); end total++;
        tick();
        if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL zero_idle_wr_en got=%0h want=0", bus.wr_en); end total++;
        if (bus.pending_mask !== 32'd0) begin bad++; $display("FAIL zero_pending_end got=%0h want=0", bus.pending_mask); end total++;
    endtask

    task automatic test_fill();
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 5'd1;
        bus.alu_data  = 32'h11;
        for (int k = 0; k < 4; k++) begin
            bus.mdu_valid = 1'b1;
            bus.mdu_addr  = 5'(8 + k);
            bus.mdu_data  = 32'h800 + k;
            #1;
            if (bus.mdu_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d got=%0h want=1", k, bus.mdu_ready); end total++;
            tick();
        end
        bus.alu_valid = 1'b0;
        bus.mdu_addr  = 5'd12;
        bus.mdu_data  = 32'hC00;
        #1;
        if (bus.mdu_ready !== 1'b0) begin bad++; $display("FAIL fill_full got=%0h want=0", bus.mdu_ready); end total++;
        if (bus.pending_mask !== 32'h00000F00) begin bad++; $display("FAIL fill_pending got=%0h want=f00", bus.pending_mask); end total++;
        tick();
        bus.mdu_valid = 1'b0;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd8 || bus.wr_data !== 32'h800) begin
            bad++; $display("FAIL fill_drain_0 got en=%0h addr=%0d data=%0h want en=1 addr=8 data=800", bus.wr_en, bus.wr_addr, bus.wr_data);
        end total++;
        if (bus.pending_mask !== 32'h00000E00) begin bad++; $display("FAIL fill_pending_pop got=%0h want=e00", bus.pending_mask); end total++;
        for (int k = 1; k < 4; k++) begin
            tick();
            if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'(8 + k) || bus.wr_data !== 32'h800 + k) begin
                bad++; $display("FAIL fill_drain_%0d got en=%0h addr=%0d data=%0h want en=1 addr=%0d data=%0h", k, bus.wr_en, bus.wr_addr, bus.wr_data, 8 + k, 32'h800 + k);
            end total++;
        end
        if (bus.pending_mask !== 32'd0) begin bad++; $display("FAIL fill_pending_empty got=%0h want=0", bus.pending_mask); end total++;
        if (bus.mdu_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_end got=%0h want=1", bus.mdu_ready); end total++;
        tick();
        if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL fill_no_extra got=%0h want=0", bus.wr_en); end total++;
    endtask

    task automatic test_starve();
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 5'd3;
        bus.alu_data  = 32'h33;
        bus.mdu_valid = 1'b1;
        bus.mdu_addr  = 5'd7;
        bus.mdu_data  = 32'hAAAA;
        tick();
        bus.mdu_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL starve_lost_%0d got=%0h want=1", k, bus.alu_ready); end total++;
            tick();
        end
        if (bus.alu_ready !== 1'b0) begin bad++; $display("FAIL starve_forced got=%0h want=0", bus.alu_ready); end total++;
        if (bus.pending_mask !== 32'h80) begin bad++; $display("FAIL starve_pending got=%0h want=80", bus.pending_mask); end total++;
        tick();
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd7 || bus.wr_data !== 32'hAAAA) begin
            bad++; $display("FAIL starve_write got en=%0h addr=%0d data=%0h want en=1 addr=7 data=aaaa", bus.wr_en, bus.wr_addr, bus.wr_data);
        end total++;
        if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL starve_release got=%0h want=1", bus.alu_ready); end total++;
        tick();
        bus.alu_valid = 1'b0;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd3 || bus.wr_data !== 32'h33) begin
            bad++; $display("FAIL starve_alu got en=%0h addr=%0d data=%0h want en=1 addr=3 data=33", bus.wr_en, bus.wr_addr, bus.wr_data);
        end total++;
        tick();
    endtask

    task automatic test_back_to_back();
        bus.mdu_valid = 1'b1;
        bus.mdu_addr  = 5'd4;
        bus.mdu_data  = 32'h44;
        tick();
        bus.mdu_addr  = 5'd6;
        bus.mdu_data  = 32'h66;
        if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL b2b_push_wr_en got=%0h want=0", bus.wr_en); end total++;
        if (bus.pending_mask !== 32'h10) begin bad++; $display("FAIL b2b_pending_a got=%0h want=10", bus.pending_mask); end total++;
        tick();
        bus.mdu_valid = 1'b0;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd4 || bus.wr_data !== 32'h44) begin
            bad++; $display("FAIL b2b_first got en=%0h addr=%0d data=%0h want en=1 addr=4 data=44", bus.wr_en, bus.wr_addr, bus.wr_data);
        end total++;
        if (bus.pending_mask !== 32'h40) begin bad++; $display("FAIL b2b_pending_b got=%0h want=40", bus.pending_mask); end total++;
        tick();
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd6 || bus.wr_data !== 32'h66) begin
            bad++; $display("FAIL b2b_second got en=%0h addr=%0d data=%0h want en=1 addr=6 data=66", bus.wr_en, bus.wr_addr, bus.wr_data);
        end total++;
        if (bus.pending_mask !== 32'd0) begin bad++; $display("FAIL b2b_pending_c got=%0h want=0", bus.pending_mask); end total++;
        tick();
    endtask

    task automatic test_midreset();
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 5'd2;
        bus.alu_data  = 32'h22;
        for (int k = 0; k < 3; k++) begin
            bus.mdu_valid = 1'b1;
            bus.mdu_addr  = 5'(20 + k);
            bus.mdu_data  = 32'h2000 + k;
            tick();
        end
        bus.mdu_valid = 1'b0;
        #1;
        if (bus.pending_mask !== 32'h00700000) begin bad++; $display("FAIL midrst_pending_before got=%0h want=700000", bus.pending_mask); end total++;
        rst = 1'b1;
        bus.alu_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL midrst_wr_en got=%0h want=0", bus.wr_en); end total++;
        if (bus.wr_addr !== 5'd0) begin bad++; $display("FAIL midrst_wr_addr got=%0h want=0", bus.wr_addr); end total++;
        if (bus.pending_mask !== 32'd0) begin bad++; $display("FAIL midrst_pending got=%0h want=0", bus.pending_mask); end total++;
        if (bus.mdu_ready !== 1'b1) begin bad++; $display("FAIL midrst_mdu_ready got=%0h want=1", bus.mdu_ready); end total++;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL midrst_no_write_%0d got=%0h want=0", k, bus.wr_en); end total++;
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_zero();
        test_fill();
        test_starve();
        test_back_to_back();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
